// File: rtl/object_bbox_locator.sv
// Finds the bounding box of run-length-filtered matched pixels in one frame and
// reports its bottom-centre (ground-contact point) once per completed frame.
module object_bbox_locator #(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int NOISE_RUN  = 4,
  parameter int MIN_PIXELS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_detect,
  output logic [10:0] x_coord,
  output logic [10:0] y_coord,
  output logic        obj_found,
  output logic        out_valid,
  output logic        frame_drop
);

  localparam int CW = 11;
  localparam int RW = $clog2(NOISE_RUN + 1);
  localparam int PW = 20;

  typedef enum logic [1:0] {WAIT_SOP, ACCUM, CALC, OUT} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] x_cnt, y_cnt;
  logic [RW-1:0] run_cnt;
  logic [CW-1:0] min_x, max_x, min_y, max_y;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] x_calc, y_calc;
  logic          found_calc;

  logic          take;
  logic [CW-1:0] pos_x, pos_y, start_x;
  logic [RW-1:0] run_base, run_nxt;
  logic [CW-1:0] min_x_b, max_x_b, min_y_b, max_y_b;
  logic [PW-1:0] pix_b;
  logic          has_box, last_col, first_hit, more_hit;
  logic [CW-1:0] x_nxt, y_nxt;
  logic [CW-1:0] min_x_n, max_x_n, min_y_n, max_y_n;
  logic [PW-1:0] pix_n;

  function automatic logic [PW-1:0] pix_sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PW] ? {PW{1'b1}} : s[PW-1:0];
  endfunction

  // Widened sum so min_x+max_x never overflows before the halving.
  function automatic logic [CW-1:0] centre(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW:1];
  endfunction

  function automatic logic [CW-1:0] umin(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] umax(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign take = in_valid && ((state == WAIT_SOP && in_sop) || state == ACCUM);

  always_comb begin
    // A sop beat always starts from a clean frame, whichever state sees it.
    pos_x    = in_sop ? '0 : x_cnt;
    pos_y    = in_sop ? '0 : y_cnt;
    run_base = in_sop ? '0 : run_cnt;
    min_x_b  = in_sop ? '0 : min_x;
    max_x_b  = in_sop ? '0 : max_x;
    min_y_b  = in_sop ? '0 : min_y;
    max_y_b  = in_sop ? '0 : max_y;
    pix_b    = in_sop ? '0 : pix_cnt;
    has_box  = (pix_b != '0);
    last_col = (pos_x == CW'(IMAGE_W - 1));
    start_x  = pos_x - CW'(NOISE_RUN - 1);

    run_nxt = '0;
    if (in_detect)
      run_nxt = (run_base == RW'(NOISE_RUN)) ? run_base : run_base + 1'b1;

    x_nxt = last_col ? '0 : pos_x + 1'b1;
    y_nxt = (last_col && pos_y != CW'(IMAGE_H - 1)) ? pos_y + 1'b1 : pos_y;

    first_hit = in_detect && (run_base == RW'(NOISE_RUN - 1));
    more_hit  = in_detect && (run_base == RW'(NOISE_RUN));

    min_x_n = min_x_b;
    max_x_n = max_x_b;
    min_y_n = min_y_b;
    max_y_n = max_y_b;
    pix_n   = pix_b;
    if (first_hit) begin
      min_x_n = has_box ? umin(min_x_b, start_x) : start_x;
      max_x_n = has_box ? umax(max_x_b, pos_x)   : pos_x;
      min_y_n = has_box ? umin(min_y_b, pos_y)   : pos_y;
      max_y_n = has_box ? umax(max_y_b, pos_y)   : pos_y;
      pix_n   = pix_sat_add(pix_b, PW'(NOISE_RUN));
    end else if (more_hit) begin
      max_x_n = umax(max_x_b, pos_x);
      pix_n   = pix_sat_add(pix_b, PW'(1));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOP: if (in_valid && in_sop) state_nxt = in_eop ? CALC : ACCUM;
      ACCUM:    if (in_valid && in_eop) state_nxt = CALC;
      CALC:     state_nxt = OUT;
      OUT:      state_nxt = WAIT_SOP;
      default:  state_nxt = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SOP;
      x_cnt      <= '0;
      y_cnt      <= '0;
      run_cnt    <= '0;
      min_x      <= '0;
      max_x      <= '0;
      min_y      <= '0;
      max_y      <= '0;
      pix_cnt    <= '0;
      x_calc     <= '0;
      y_calc     <= '0;
      found_calc <= 1'b0;
      x_coord    <= '0;
      y_coord    <= '0;
      obj_found  <= 1'b0;
      out_valid  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_valid  <= 1'b0;
      frame_drop <= 1'b0;
      // stage: pixel accumulation
      if (take) begin
        x_cnt   <= x_nxt;
        y_cnt   <= y_nxt;
        run_cnt <= last_col ? '0 : run_nxt;
        min_x   <= min_x_n;
        max_x   <= max_x_n;
        min_y   <= min_y_n;
        max_y   <= max_y_n;
        pix_cnt <= pix_n;
        if (state == ACCUM && in_sop) frame_drop <= 1'b1;
      end
      // stage: box centre calculation
      if (state == CALC) begin
        x_calc     <= (pix_cnt != '0) ? centre(min_x, max_x) : '0;
        y_calc     <= (pix_cnt != '0) ? max_y : '0;
        found_calc <= (pix_cnt >= PW'(MIN_PIXELS));
      end
      // stage: output register
      if (state == OUT) begin
        x_coord   <= x_calc;
        y_coord   <= y_calc;
        obj_found <= found_calc;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
